// File: rtl/dpram_bist_ctrl.sv
// Dual-port RAM BIST controller: writes seed-derived patterns on one port and
// reads them back on the other, logging mismatches.
// Optional inverse phases (write B with ~pattern, read back on A) are enabled
// by defining BIST_INV_PHASE_EN.
module dpram_bist_ctrl #(
  parameter int unsigned length   = 8,
  parameter int unsigned location = 16,
  localparam int unsigned AW      = (location > 1) ? $clog2(location) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [length-1:0] seed,
  output logic              a_rw,
  output logic              b_rw,
  output logic [AW-1:0]     a_w_addr,
  output logic [AW-1:0]     b_w_addr,
  output logic [AW-1:0]     a_r_addr,
  output logic [AW-1:0]     b_r_addr,
  output logic [length-1:0] a_indata,
  output logic [length-1:0] b_indata,
  input  logic [length-1:0] a_outdata,
  input  logic [length-1:0] b_outdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [AW-1:0]     fail_addr,
  output logic              fail_port,
  output logic [AW:0]       err_cnt
);

  localparam logic [AW-1:0] LAST = AW'(location - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    RD_B,
`ifdef BIST_INV_PHASE_EN
    WR_B,
    RD_A,
`endif
    DONE
  } state_t;

  state_t              state, state_nxt;
  logic [AW-1:0]       cnt, cnt_nxt;
  logic                tail, tail_nxt;
  logic [length-1:0]   seed_q, seed_nxt;
  logic                cmp_vld, cmp_vld_nxt;
  logic                cmp_port, cmp_port_nxt;
  logic [AW-1:0]       cmp_addr, cmp_addr_nxt;
  logic [length-1:0]   rd_data, rd_exp;
  logic                mismatch;

  logic                a_rw_nxt, b_rw_nxt, busy_nxt, done_nxt, pass_nxt, fail_port_nxt;
  logic [AW-1:0]       a_w_addr_nxt, b_w_addr_nxt, a_r_addr_nxt, b_r_addr_nxt, fail_addr_nxt;
  logic [length-1:0]   a_indata_nxt, b_indata_nxt;
  logic [AW:0]         err_cnt_nxt;

  function automatic logic [length-1:0] pat(input logic [length-1:0] s, input logic [AW-1:0] x);
    return s ^ length'(x);
  endfunction

  // Read data returned this cycle versus the pattern for the address issued last cycle
  always_comb begin
    rd_data  = cmp_port ? a_outdata : b_outdata;
    rd_exp   = cmp_port ? ~pat(seed_q, cmp_addr) : pat(seed_q, cmp_addr);
    mismatch = cmp_vld && (rd_data != rd_exp);
  end

  // Next-state, counter, result and registered-output computation
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    tail_nxt      = tail;
    seed_nxt      = seed_q;
    cmp_vld_nxt   = 1'b0;
    cmp_port_nxt  = 1'b0;
    cmp_addr_nxt  = '0;
    pass_nxt      = pass;
    err_cnt_nxt   = err_cnt;
    fail_addr_nxt = fail_addr;
    fail_port_nxt = fail_port;

    if (mismatch) begin
      pass_nxt = 1'b0;
      if (err_cnt != '1) err_cnt_nxt = err_cnt + 1'b1;
      if (pass) begin
        fail_addr_nxt = cmp_addr;
        fail_port_nxt = cmp_port;
      end
    end

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt     = WR_A;
          cnt_nxt       = '0;
          tail_nxt      = 1'b0;
          seed_nxt      = seed;
          pass_nxt      = 1'b1;
          err_cnt_nxt   = '0;
          fail_addr_nxt = '0;
          fail_port_nxt = 1'b0;
        end
      end
      WR_A: begin
        if (cnt == LAST) begin
          state_nxt = RD_B;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RD_B: begin
        if (!tail) begin
          cmp_vld_nxt  = 1'b1;
          cmp_addr_nxt = cnt;
          if (cnt == LAST) begin
            tail_nxt = 1'b1;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          tail_nxt = 1'b0;
`ifdef BIST_INV_PHASE_EN
          state_nxt = WR_B;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef BIST_INV_PHASE_EN
      WR_B: begin
        if (cnt == LAST) begin
          state_nxt = RD_A;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RD_A: begin
        if (!tail) begin
          cmp_vld_nxt  = 1'b1;
          cmp_port_nxt = 1'b1;
          cmp_addr_nxt = cnt;
          if (cnt == LAST) begin
            tail_nxt = 1'b1;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else begin
          tail_nxt  = 1'b0;
          state_nxt = DONE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    // RAM-side outputs follow the upcoming state so they line up with it
    a_rw_nxt     = (state_nxt == WR_A);
    a_w_addr_nxt = a_rw_nxt ? cnt_nxt : '0;
    a_indata_nxt = a_rw_nxt ? pat(seed_nxt, cnt_nxt) : '0;
    b_r_addr_nxt = (state_nxt == RD_B && !tail_nxt) ? cnt_nxt : '0;
`ifdef BIST_INV_PHASE_EN
    b_rw_nxt     = (state_nxt == WR_B);
    b_w_addr_nxt = b_rw_nxt ? cnt_nxt : '0;
    b_indata_nxt = b_rw_nxt ? ~pat(seed_nxt, cnt_nxt) : '0;
    a_r_addr_nxt = (state_nxt == RD_A && !tail_nxt) ? cnt_nxt : '0;
`else
    b_rw_nxt     = 1'b0;
    b_w_addr_nxt = '0;
    b_indata_nxt = '0;
    a_r_addr_nxt = '0;
`endif
    busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
    done_nxt = (state_nxt == DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tail      <= 1'b0;
      seed_q    <= '0;
      cmp_vld   <= 1'b0;
      cmp_port  <= 1'b0;
      cmp_addr  <= '0;
      a_rw      <= 1'b0;
      b_rw      <= 1'b0;
      a_w_addr  <= '0;
      b_w_addr  <= '0;
      a_r_addr  <= '0;
      b_r_addr  <= '0;
      a_indata  <= '0;
      b_indata  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b1;
      fail_addr <= '0;
      fail_port <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tail      <= tail_nxt;
      seed_q    <= seed_nxt;
      cmp_vld   <= cmp_vld_nxt;
      cmp_port  <= cmp_port_nxt;
      cmp_addr  <= cmp_addr_nxt;
      a_rw      <= a_rw_nxt;
      b_rw      <= b_rw_nxt;
      a_w_addr  <= a_w_addr_nxt;
      b_w_addr  <= b_w_addr_nxt;
      a_r_addr  <= a_r_addr_nxt;
      b_r_addr  <= b_r_addr_nxt;
      a_indata  <= a_indata_nxt;
      b_indata  <= b_indata_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      fail_addr <= fail_addr_nxt;
      fail_port <= fail_port_nxt;
      err_cnt   <= err_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_dpram_bist_ctrl.sv
// Testbench for dpram_bist_ctrl with a behavioural dual-port RAM and fault hooks.
module tb_dpram_bist_ctrl;

`ifdef BIST_INV_PHASE_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif
  localparam int RUN = INV ? 66 : 33;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] seed;
  logic       a_rw, b_rw;
  logic [3:0] a_w_addr, b_w_addr, a_r_addr, b_r_addr;
  logic [7:0] a_indata, b_indata, a_outdata, b_outdata;
  logic       busy, done, pass, fail_port;
  logic [3:0] fail_addr;
  logic [4:0] err_cnt;

  // Fault controls
  bit flip_b5, a_zero, b_zero;

  int checks = 0;
  int failures = 0;

  // Per-run observations
  int         cycles;
  logic [7:0] a3, b3;
  bit         conflict, b_seen, busy_bad;

  always #5 clk = ~clk;

  dpram_bist_ctrl #(.length(8), .location(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .a_rw(a_rw), .b_rw(b_rw),
    .a_w_addr(a_w_addr), .b_w_addr(b_w_addr),
    .a_r_addr(a_r_addr), .b_r_addr(b_r_addr),
    .a_indata(a_indata), .b_indata(b_indata),
    .a_outdata(a_outdata), .b_outdata(b_outdata),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_port(fail_port), .err_cnt(err_cnt)
  );

  // Behavioural dual-port RAM with one-cycle registered read
  logic [7:0] mem [16];
  logic [7:0] a_q, b_q;
  logic [3:0] b_ra_q;
  always @(posedge clk) begin
    if (a_rw) mem[a_w_addr] <= a_indata;
    if (b_rw) mem[b_w_addr] <= b_indata;
    a_q    <= mem[a_r_addr];
    b_q    <= mem[b_r_addr];
    b_ra_q <= b_r_addr;
  end
  assign a_outdata = a_zero ? 8'h00 : a_q;
  assign b_outdata = b_zero ? 8'h00 : (b_q ^ {7'b0, (flip_b5 && b_ra_q == 4'd5)});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start a test and follow it until done, an abort cycle, or a cycle budget
  task automatic run_test(input logic [7:0] sd, input int pulse_at, input int abort_at);
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seed  = ~sd;
    cycles = 0; a3 = 8'h00; b3 = 8'h00;
    conflict = 1'b0; b_seen = 1'b0; busy_bad = 1'b0;
    while (!done && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
      if (a_rw && b_rw) conflict = 1'b1;
      if (b_rw) b_seen = 1'b1;
      if (a_rw && a_w_addr == 4'd3) a3 = a_indata;
      if (b_rw && b_w_addr == 4'd3) b3 = b_indata;
      if (!done && !busy) busy_bad = 1'b1;
      if (cycles == pulse_at) begin
        start = 1'b1;
        seed  = 8'h00;
      end else begin
        start = 1'b0;
      end
      if (cycles == abort_at) begin
        rst_n = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] seed;
    bit         flip;
    bit         az;
    bit         bz;
    bit         pass;
    int         err;
    int         faddr;
    bit         fport;
  } vec_t;

  vec_t tbl[7];

  initial begin
    rst_n = 1'b0; start = 1'b0; seed = 8'h00;
    flip_b5 = 1'b0; a_zero = 1'b0; b_zero = 1'b0;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1, 5, 1'b0};
    tbl[2] = '{8'h5A, 1'b0, 1'b1, 1'b0, !INV, INV ? 16 : 0, 0, INV};
    tbl[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, INV ? 17 : 1, 5, 1'b0};
    tbl[5] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, INV ? 31 : 16, 0, 1'b0};
    tbl[6] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 15, 1, 1'b0};

    // Reset values asserted without any clock dependence
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 1);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_rw", 32'({a_rw, b_rw}), 0);
    chk("rst_fail", 32'({fail_addr, fail_port}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    foreach (tbl[i]) begin
      flip_b5 = tbl[i].flip;
      a_zero  = tbl[i].az;
      b_zero  = tbl[i].bz;
      run_test(tbl[i].seed, 0, 0);
      chk($sformatf("v%0d_cycles", i), 32'(cycles), 32'(RUN));
      chk($sformatf("v%0d_pass", i), 32'(pass), 32'(tbl[i].pass));
      chk($sformatf("v%0d_err", i), 32'(err_cnt), 32'(tbl[i].err));
      chk($sformatf("v%0d_faddr", i), 32'(fail_addr), 32'(tbl[i].faddr));
      chk($sformatf("v%0d_fport", i), 32'(fail_port), 32'(tbl[i].fport));
      chk($sformatf("v%0d_a3", i), 32'(a3), 32'(tbl[i].seed ^ 8'h03));
      chk($sformatf("v%0d_b3", i), 32'(b3), INV ? 32'(~(tbl[i].seed ^ 8'h03)) : 32'd0);
      chk($sformatf("v%0d_bseen", i), 32'(b_seen), 32'(INV));
      chk($sformatf("v%0d_conflict", i), 32'(conflict), 0);
      chk($sformatf("v%0d_busy", i), 32'(busy_bad), 0);
    end
    flip_b5 = 1'b0; a_zero = 1'b0; b_zero = 1'b0;

    // Results are held in DONE
    repeat (5) @(negedge clk);
    chk("hold_done", 32'(done), 1);
    chk("hold_err", 32'(err_cnt), 15);

    // Spec example values on a healthy RAM
    run_test(8'hA5, 0, 0);
    chk("a5_a3", 32'(a3), 32'h0A6);
    chk("a5_b3", 32'(b3), INV ? 32'h059 : 32'h0);

    // Start while busy is ignored
    run_test(8'hA5, 10, 0);
    chk("pulse_cycles", 32'(cycles), 32'(RUN));
    chk("pulse_pass", 32'(pass), 1);
    chk("pulse_a3", 32'(a3), 32'h0A6);

    // Reset mid-test with errors already logged
    b_zero = 1'b1;
    run_test(8'h5A, 0, 20);
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_rw", 32'({a_rw, b_rw}), 0);
    chk("abort_pass", 32'(pass), 1);
    chk("abort_err", 32'(err_cnt), 0);
    b_zero = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_test(8'hA5, 0, 0);
    chk("rerun_cycles", 32'(cycles), 32'(RUN));
    chk("rerun_pass", 32'(pass), 1);
    chk("rerun_err", 32'(err_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
